// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: opcodes, FSM state encoding and helpers shared by alu_share_ctrl.
package alu_ctrl_pkg;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    function automatic logic is_legal_op(input logic [2:0] op);
        return !op[2];
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr.
module rr_arbiter #(
    parameter int N = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx
);
    // Scan from the farthest offset down so the nearest request to ptr wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                gnt                          = '0;
                gnt[(int'(ptr) + k) % N]     = 1'b1;
                gnt_idx                      = PW'((int'(ptr) + k) % N);
            end
        end
    end
endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin sharing of one external ALU between N_REQ requesters,
// with registered operands, a one-cycle execute slot and a held response.
module alu_share_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int W     = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [3*N_REQ-1:0] req_op,
    input  logic [W*N_REQ-1:0] req_a,
    input  logic [W*N_REQ-1:0] req_b,
    output logic [N_REQ-1:0]   rsp_valid,
    input  logic [N_REQ-1:0]   rsp_ready,
    output logic [W-1:0]       rsp_result,
    output logic               rsp_zero,
    output logic               rsp_err,
    output logic               busy,
    output logic [W-1:0]       alu_in1,
    output logic [W-1:0]       alu_in2,
    output logic [2:0]         alu_ctrl,
    input  logic [W-1:0]       alu_result
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [N_REQ-1:0] LSB = N_REQ'(1);

    state_t        r_state, w_next;
    logic [PW-1:0] r_rr_ptr, r_own, w_gnt_idx, w_ptr_nxt;
    logic [N_REQ-1:0] w_gnt;
    logic [2:0]    r_op;
    logic [W-1:0]  r_a, r_b, r_result;
    logic          r_zero, r_err;
    logic          w_accept, w_drive;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req     (req_valid),
        .ptr     (r_rr_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    assign w_accept  = (r_state == S_IDLE) && (|req_valid);
    assign w_ptr_nxt = (w_gnt_idx == PW'(N_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
    // Illegal ops never reach the ALU: its inputs stay at zero.
    assign w_drive   = (r_state == S_EXEC) && is_legal_op(r_op);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = (|req_valid) ? S_EXEC : S_IDLE;
            S_EXEC:  w_next = S_RESP;
            S_RESP:  w_next = rsp_ready[r_own] ? S_IDLE : S_RESP;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= '0;
            r_own    <= '0;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_own    <= w_gnt_idx;
                r_op     <= req_op[3*w_gnt_idx +: 3];
                r_a      <= req_a[W*w_gnt_idx +: W];
                r_b      <= req_b[W*w_gnt_idx +: W];
                r_rr_ptr <= w_ptr_nxt;
            end
            if (r_state == S_EXEC) begin
                r_result <= w_drive ? alu_result : '0;
                r_zero   <= w_drive ? (alu_result == '0) : 1'b1;
                r_err    <= !w_drive;
            end
        end
    end

    assign req_ready  = (r_state == S_IDLE && !reset) ? w_gnt : '0;
    assign rsp_valid  = (r_state == S_RESP) ? (LSB << r_own) : '0;
    assign rsp_result = r_result;
    assign rsp_zero   = r_zero;
    assign rsp_err    = r_err;
    assign busy       = (r_state != S_IDLE);
    assign alu_in1    = w_drive ? r_a : '0;
    assign alu_in2    = w_drive ? r_b : '0;
    assign alu_ctrl   = w_drive ? r_op : 3'b000;
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed stimulus against a transaction-level model of the shared ALU controller.
module tb_alu_share_ctrl;
    import alu_ctrl_pkg::*;
    localparam int N = 2;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   rsp_ready = '0;
    logic [3*N-1:0] req_op = '0;
    logic [W*N-1:0] req_a = '0;
    logic [W*N-1:0] req_b = '0;
    logic [N-1:0]   req_ready, rsp_valid;
    logic [W-1:0]   rsp_result, alu_in1, alu_in2, alu_result;
    logic           rsp_zero, rsp_err, busy;
    logic [2:0]     alu_ctrl;

    int checks = 0;
    int failures = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    alu_share_ctrl #(.N_REQ(N), .W(W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .busy(busy),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result)
    );

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            default: return 32'd0;
        endcase
    endfunction

    // The external ALU the controller drives.
    assign alu_result = ref_alu(alu_ctrl, alu_in1, alu_in2);

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one transaction in flight, aged 1 in the execute cycle and 2 while responding.
    bit          m_busy = 1'b0;
    int          m_age = 0, m_own = 0, m_ptr = 0, m_g;
    logic [2:0]  m_op = '0, g_op;
    logic [31:0] m_a = '0, m_b = '0, g_a, g_b;

    always_comb begin
        m_g  = pick(req_valid, m_ptr);
        g_op = req_op[3*m_g +: 3];
        g_a  = req_a[W*m_g +: W];
        g_b  = req_b[W*m_g +: W];
    end

    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_ptr  <= 0;
            m_age  <= 0;
        end else if (!m_busy) begin
            if (|req_valid) begin
                m_busy <= 1'b1;
                m_age  <= 1;
                m_own  <= m_g;
                m_op   <= g_op;
                m_a    <= g_a;
                m_b    <= g_b;
                m_ptr  <= (m_g + 1) % N;
            end
        end else if (m_age == 1) begin
            m_age <= 2;
        end else if (rsp_ready[m_own]) begin
            m_busy <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("m_req_ready", 32'(req_ready), (!m_busy && !reset && |req_valid) ? 32'(1 << m_g) : 32'd0);
            chk("m_rsp_valid", 32'(rsp_valid), (m_busy && m_age == 2) ? 32'(1 << m_own) : 32'd0);
            chk("m_busy", 32'(busy), 32'(m_busy));
            if (m_busy && m_age == 2) begin
                chk("m_result", rsp_result, ref_alu(m_op, m_a, m_b));
                chk("m_zero", 32'(rsp_zero), 32'(ref_alu(m_op, m_a, m_b) == 32'd0));
                chk("m_err", 32'(rsp_err), 32'(m_op[2]));
            end
            if (m_busy && m_age == 1) begin
                chk("m_alu_ctrl", 32'(alu_ctrl), m_op[2] ? 32'd0 : 32'(m_op));
                chk("m_alu_in1", alu_in1, m_op[2] ? 32'd0 : m_a);
                chk("m_alu_in2", alu_in2, m_op[2] ? 32'd0 : m_b);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int r, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op[3*r +: 3] = op;
        req_a[W*r +: W]  = a;
        req_b[W*r +: W]  = b;
        req_valid[r]     = 1'b1;
    endtask

    // Leaves the caller at the negedge of the cycle in which requester r is granted.
    task automatic wait_ready(input int r);
        int n = 0;
        @(negedge clk);
        while (!req_ready[r] && n < 20) begin
            step();
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(req_ready[r]), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_result"}, rsp_result, 32'd0);
        chk({tag, "_zero"}, 32'(rsp_zero), 32'd0);
        chk({tag, "_err"}, 32'(rsp_err), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_in1"}, alu_in1, 32'd0);
        chk({tag, "_in2"}, alu_in2, 32'd0);
        chk({tag, "_ctrl"}, 32'(alu_ctrl), 32'd0);
    endtask

    task automatic run_op(input int r, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input logic ez, input logic ee);
        rsp_ready = '1;
        set_req(r, op, a, b);
        wait_ready(r);
        step();
        req_valid[r] = 1'b0;
        @(negedge clk);
        chk("exec_ctrl", 32'(alu_ctrl), ee ? 32'd0 : 32'(op));
        chk("exec_in1", alu_in1, ee ? 32'd0 : a);
        chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        step();
        @(negedge clk);
        chk("rsp_valid", 32'(rsp_valid), 32'(1 << r));
        chk("rsp_result", rsp_result, exp);
        chk("rsp_zero", 32'(rsp_zero), 32'(ez));
        chk("rsp_err", 32'(rsp_err), 32'(ee));
        step();
    endtask

    initial begin
        int grants[$];
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        started = 1'b1;
        @(negedge clk);
        check_all_zero("reset");
        step();

        run_op(0, OP_ADD, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
        run_op(1, OP_SUB, 32'd3, 32'd3, 32'd0, 1'b1, 1'b0);
        run_op(1, OP_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op(0, OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0, 1'b0);
        run_op(1, OP_OR,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFFF0_FFFF, 1'b0, 1'b0);
        run_op(0, OP_ADD, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0, 1'b0);
        run_op(1, OP_SUB, 32'd10, 32'd3, 32'd7, 1'b0, 1'b0);
        run_op(0, 3'b110, 32'd9, 32'd4, 32'd0, 1'b1, 1'b1);

        // Backpressure on requester 0; requester 1's ready bit must be ignored.
        rsp_ready = 2'b10;
        set_req(0, OP_ADD, 32'd100, 32'd23);
        wait_ready(0);
        step();
        req_valid[0] = 1'b0;
        set_req(1, OP_OR, 32'd1, 32'd2);
        step();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_result", rsp_result, 32'd123);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            step();
        end
        rsp_ready = 2'b01;
        @(negedge clk);
        chk("bp_last_valid", 32'(rsp_valid), 32'd1);
        step();
        rsp_ready = 2'b11;
        @(negedge clk);
        chk("bp_next_grant", 32'(req_ready), 32'd2);
        step();
        req_valid[1] = 1'b0;
        step();
        @(negedge clk);
        chk("bp_or_result", rsp_result, 32'd3);
        step();

        // Reset while requester 1 is responding.
        rsp_ready = '0;
        set_req(1, OP_SUB, 32'd8, 32'd5);
        wait_ready(1);
        step();
        req_valid[1] = 1'b0;
        step();
        @(negedge clk);
        chk("rst1_rsp_valid", 32'(rsp_valid), 32'd2);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("rst1");
        rsp_ready = '1;
        for (int i = 0; i < 4; i++) begin
            step();
            @(negedge clk);
            chk("rst1_no_stale", 32'(rsp_valid), 32'd0);
        end
        step();

        // Both requesters continuously valid: grants rotate 0,1,0,1.
        set_req(0, OP_ADD, 32'd1, 32'd1);
        set_req(1, OP_SUB, 32'd5, 32'd2);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (req_ready != '0) grants.push_back(req_ready[1] ? 1 : 0);
            step();
        end
        req_valid = '0;
        chk("rr_count", 32'(grants.size()), 32'd4);
        for (int i = 0; i < grants.size() && i < 4; i++)
            chk("rr_order", 32'(grants[i]), 32'(i % 2));
        step();
        step();
        step();

        // Reset with rr_ptr at 1 must restart arbitration at requester 0.
        rsp_ready = '0;
        set_req(0, OP_ADD, 32'd2, 32'd2);
        wait_ready(0);
        step();
        req_valid[0] = 1'b0;
        step();
        @(negedge clk);
        chk("rst2_rsp_valid", 32'(rsp_valid), 32'd1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        req_valid = 2'b11;
        @(negedge clk);
        chk("rst2_grant", 32'(req_ready), 32'd1);
        step();
        req_valid = '0;
        rsp_ready = '1;
        step();
        @(negedge clk);
        chk("rst2_result", rsp_result, 32'd4);
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
